// File: rtl/oursring_req_rr_arbiter.sv
// Ring request arbiter: round-robin AR and AW arbitration with grant lock,
// plus a W ordering queue that follows the order of AW grants.
module oursring_req_rr_arbiter_ch #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          block,
    input  logic [N-1:0]  req_valid,
    output logic [N-1:0]  req_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sel,
    output logic          hs,
    output logic [IW-1:0] hs_idx
);
    localparam logic [N-1:0] ONE = 1;

    logic [IW-1:0] ptr, lock_idx, pick, idx;
    logic          lock, pick_ok, act;
    int            cand;

    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            if (!pick_ok && req_valid[IW'(cand)]) begin
                pick_ok = 1'b1;
                pick    = IW'(cand);
            end
        end
        // A stalled grant keeps its port regardless of newer requests
        idx       = lock ? lock_idx : pick;
        act       = !rst && !block && (lock || pick_ok);
        out_valid = act && req_valid[idx];
        sel       = act ? (ONE << idx) : '0;
        req_ready = (act && out_ready) ? (ONE << idx) : '0;
        hs        = out_valid && out_ready;
        hs_idx    = idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (hs) begin
            ptr  <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
            lock <= 1'b0;
        end else if (out_valid) begin
            lock     <= 1'b1;
            lock_idx <= idx;
        end
    end
endmodule

module oursring_req_rr_arbiter #(
    parameter int N_IN_PORT = 3,
    parameter int WQ_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN_PORT-1:0] i_arvalid,
    output logic [N_IN_PORT-1:0] i_arready,
    output logic                 o_arvalid,
    input  logic                 o_arready,
    output logic [N_IN_PORT-1:0] o_ar_sel,
    input  logic [N_IN_PORT-1:0] i_awvalid,
    output logic [N_IN_PORT-1:0] i_awready,
    output logic                 o_awvalid,
    input  logic                 o_awready,
    output logic [N_IN_PORT-1:0] o_aw_sel,
    input  logic [N_IN_PORT-1:0] i_wvalid,
    input  logic [N_IN_PORT-1:0] i_wlast,
    output logic [N_IN_PORT-1:0] i_wready,
    output logic                 o_wvalid,
    input  logic                 o_wready,
    output logic [N_IN_PORT-1:0] o_w_sel
);
    localparam int IW = $clog2(N_IN_PORT);
    localparam int QW = $clog2(WQ_DEPTH);
    localparam logic [N_IN_PORT-1:0] ONE = 1;

    logic          ar_hs, aw_hs, full, w_act, pop;
    logic [IW-1:0] ar_idx, aw_idx, head;
    logic [IW-1:0] wq [WQ_DEPTH];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   count;

    oursring_req_rr_arbiter_ch #(.N(N_IN_PORT), .IW(IW)) u_ar (
        .clk(clk), .rst(rst), .block(1'b0),
        .req_valid(i_arvalid), .req_ready(i_arready),
        .out_valid(o_arvalid), .out_ready(o_arready), .sel(o_ar_sel),
        .hs(ar_hs), .hs_idx(ar_idx)
    );

    // AW is held off while the order queue is full so no grant is lost
    oursring_req_rr_arbiter_ch #(.N(N_IN_PORT), .IW(IW)) u_aw (
        .clk(clk), .rst(rst), .block(full),
        .req_valid(i_awvalid), .req_ready(i_awready),
        .out_valid(o_awvalid), .out_ready(o_awready), .sel(o_aw_sel),
        .hs(aw_hs), .hs_idx(aw_idx)
    );

    assign full     = (count == (QW + 1)'(WQ_DEPTH));
    assign head     = wq[rd_ptr];
    assign w_act    = !rst && (count != '0);
    assign o_wvalid = w_act && i_wvalid[head];
    assign o_w_sel  = w_act ? (ONE << head) : '0;
    assign i_wready = (w_act && o_wready) ? (ONE << head) : '0;
    assign pop      = o_wvalid && o_wready && i_wlast[head];

    always_ff @(posedge clk) begin
        if (aw_hs) wq[wr_ptr] <= aw_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (aw_hs) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({aw_hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(i_arready));
            assert ($onehot0(i_awready));
            assert ($onehot0(i_wready));
            assert (count <= (QW + 1)'(WQ_DEPTH));
        end
    end
`endif
endmodule

// File: tb/tb_oursring_req_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and point probes,
// a negedge monitor pops and compares them.
module tb_oursring_req_rr_arbiter;
    localparam int N = 3;

    localparam int P_ARSEL = 0, P_ARVALID = 1, P_ARREADY = 2;
    localparam int P_AWSEL = 3, P_AWVALID = 4, P_AWREADY = 5;
    localparam int P_WSEL = 6, P_WVALID = 7, P_WREADY = 8, P_SBLEFT = 9;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       name;
    } probe_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_arvalid, i_arready, o_ar_sel;
    logic [N-1:0] i_awvalid, i_awready, o_aw_sel;
    logic [N-1:0] i_wvalid, i_wlast, i_wready, o_w_sel;
    logic         o_arvalid, o_arready, o_awvalid, o_awready, o_wvalid, o_wready;

    int     exp_ar[$], exp_aw[$], exp_w[$];
    probe_t probes[$];
    int     checks = 0, errors = 0;

    oursring_req_rr_arbiter #(.N_IN_PORT(N), .WQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .o_arvalid(o_arvalid),
        .o_arready(o_arready), .o_ar_sel(o_ar_sel),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .o_awvalid(o_awvalid),
        .o_awready(o_awready), .o_aw_sel(o_aw_sel),
        .i_wvalid(i_wvalid), .i_wlast(i_wlast), .i_wready(i_wready),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_w_sel(o_w_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sig(int id);
        case (id)
            P_ARSEL:   return 32'(o_ar_sel);
            P_ARVALID: return 32'(o_arvalid);
            P_ARREADY: return 32'(i_arready);
            P_AWSEL:   return 32'(o_aw_sel);
            P_AWVALID: return 32'(o_awvalid);
            P_AWREADY: return 32'(i_awready);
            P_WSEL:    return 32'(o_w_sel);
            P_WVALID:  return 32'(o_wvalid);
            P_WREADY:  return 32'(i_wready);
            default:   return 32'(exp_ar.size() + exp_aw.size() + exp_w.size());
        endcase
    endfunction

    // Monitor: handshake scoreboards first, then this cycle's point probes
    always @(negedge clk) begin
        logic [N-1:0] want;
        probe_t       p;
        if (o_arvalid && o_arready) begin
            checks++;
            if (exp_ar.size() == 0) begin
                errors++;
                $display("FAIL ar_grant unexpected sel=%b", o_ar_sel);
            end else begin
                want = N'(1) << exp_ar.pop_front();
                if (o_ar_sel !== want) begin
                    errors++;
                    $display("FAIL ar_grant got %b want %b", o_ar_sel, want);
                end
            end
        end
        if (o_awvalid && o_awready) begin
            checks++;
            if (exp_aw.size() == 0) begin
                errors++;
                $display("FAIL aw_grant unexpected sel=%b", o_aw_sel);
            end else begin
                want = N'(1) << exp_aw.pop_front();
                if (o_aw_sel !== want) begin
                    errors++;
                    $display("FAIL aw_grant got %b want %b", o_aw_sel, want);
                end
            end
        end
        if (o_wvalid && o_wready) begin
            checks++;
            if (exp_w.size() == 0) begin
                errors++;
                $display("FAIL w_beat unexpected sel=%b", o_w_sel);
            end else begin
                want = N'(1) << exp_w.pop_front();
                if (o_w_sel !== want) begin
                    errors++;
                    $display("FAIL w_beat got %b want %b", o_w_sel, want);
                end
            end
        end
        while (probes.size() != 0) begin
            p = probes.pop_front();
            checks++;
            if (sig(p.id) !== p.exp) begin
                errors++;
                $display("FAIL %s got %0h want %0h", p.name, sig(p.id), p.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int id, input logic [31:0] exp, input string name);
        probe_t p;
        p.id = id; p.exp = exp; p.name = name;
        probes.push_back(p);
    endtask

    initial begin
        rst = 1'b1;
        i_arvalid = '0; i_awvalid = '0; i_wvalid = '0; i_wlast = '0;
        o_arready = 1'b0; o_awready = 1'b0; o_wready = 1'b0;
        tick(); tick();

        // Reset forces everything quiet even with requests pending
        i_arvalid = 3'b111; i_awvalid = 3'b111; i_wvalid = 3'b111;
        o_arready = 1'b1; o_awready = 1'b1; o_wready = 1'b1;
        probe(P_ARSEL, 0, "rst_ar_sel"); probe(P_ARVALID, 0, "rst_arvalid");
        probe(P_ARREADY, 0, "rst_arready"); probe(P_AWSEL, 0, "rst_aw_sel");
        probe(P_AWVALID, 0, "rst_awvalid"); probe(P_AWREADY, 0, "rst_awready");
        probe(P_WSEL, 0, "rst_w_sel"); probe(P_WVALID, 0, "rst_wvalid");
        probe(P_WREADY, 0, "rst_wready");
        tick();

        // AR fairness: 0,1,2,0,1,2 starting the first cycle out of reset
        rst = 1'b0; i_awvalid = '0; i_wvalid = '0; o_awready = 1'b0;
        foreach (exp_ar[i]) ;
        for (int i = 0; i < 6; i++) exp_ar.push_back(i % 3);
        probe(P_ARSEL, 3'b001, "first_arb_sel");
        for (int i = 0; i < 6; i++) tick();

        // AR lock: port 1 stalls three cycles while port 0 requests
        i_arvalid = 3'b010; o_arready = 1'b0;
        probe(P_ARSEL, 3'b010, "lock_c1"); probe(P_ARREADY, 0, "lock_rdy0");
        tick();
        i_arvalid = 3'b011;
        probe(P_ARSEL, 3'b010, "lock_c2"); tick();
        probe(P_ARSEL, 3'b010, "lock_c3"); tick();
        o_arready = 1'b1; exp_ar.push_back(1);
        probe(P_ARREADY, 3'b010, "lock_release_rdy"); tick();
        i_arvalid = 3'b001; exp_ar.push_back(0);
        probe(P_ARSEL, 3'b001, "after_lock_sel"); tick();

        // AW from port 2 concurrent with AR port 2; W waiting sees empty queue
        i_arvalid = 3'b100; i_awvalid = 3'b100; o_awready = 1'b1;
        i_wvalid = 3'b101; o_wready = 1'b1; i_wlast = '0;
        exp_ar.push_back(2); exp_aw.push_back(2);
        probe(P_WVALID, 0, "w_empty_t"); probe(P_WSEL, 0, "w_empty_sel");
        tick();
        i_arvalid = '0; i_awvalid = 3'b001; exp_aw.push_back(0);
        for (int i = 0; i < 4; i++) exp_w.push_back(2);
        for (int i = 0; i < 4; i++) exp_w.push_back(0);
        probe(P_WVALID, 1, "w_t1_valid"); probe(P_WREADY, 3'b100, "w_order_b1");
        tick();
        i_awvalid = '0;
        probe(P_WREADY, 3'b100, "w_order_b2"); tick();
        probe(P_WREADY, 3'b100, "w_order_b3"); tick();
        i_wlast = 3'b100;
        probe(P_WREADY, 3'b100, "w_order_b4"); tick();
        i_wvalid = 3'b001; i_wlast = '0;
        probe(P_WSEL, 3'b001, "w_port0_sel"); probe(P_WREADY, 3'b001, "w_port0_rdy");
        tick(); tick(); tick();
        i_wlast = 3'b001; tick();
        i_wlast = '0;
        probe(P_WSEL, 0, "w_drained_sel"); probe(P_WVALID, 0, "w_drained_valid");
        tick();

        // Fill the order queue: grants 1,2,0,1, then AW blocked
        i_wvalid = '0; i_awvalid = 3'b111;
        exp_aw.push_back(1); exp_aw.push_back(2); exp_aw.push_back(0); exp_aw.push_back(1);
        for (int i = 0; i < 4; i++) tick();
        probe(P_AWVALID, 0, "full_awvalid"); probe(P_AWREADY, 0, "full_awready");
        tick();
        i_wvalid = 3'b010; i_wlast = 3'b010; exp_w.push_back(1);
        probe(P_AWVALID, 0, "full_pop_same_cycle"); tick();
        i_wvalid = '0; i_wlast = '0; exp_aw.push_back(2);
        probe(P_AWVALID, 1, "after_pop_awvalid"); probe(P_AWSEL, 3'b100, "after_pop_aw_sel");
        tick();

        // Reset in the middle of port 2's burst, with AR pointer moved to 1
        i_awvalid = '0; i_wvalid = 3'b100; i_arvalid = 3'b001;
        exp_ar.push_back(0); exp_w.push_back(2); tick();
        i_arvalid = '0; exp_w.push_back(2); tick();
        rst = 1'b1; i_arvalid = 3'b111; i_awvalid = 3'b111;
        probe(P_ARSEL, 0, "mid_rst_ar_sel"); probe(P_AWVALID, 0, "mid_rst_awvalid");
        probe(P_WSEL, 0, "mid_rst_w_sel"); probe(P_WVALID, 0, "mid_rst_wvalid");
        probe(P_WREADY, 0, "mid_rst_wready");
        tick();
        rst = 1'b0; i_awvalid = '0; o_arready = 1'b0;
        probe(P_WSEL, 0, "post_rst_w_sel"); probe(P_WVALID, 0, "post_rst_wvalid");
        probe(P_ARSEL, 3'b001, "post_rst_ar_ptr");
        tick();
        i_arvalid = '0; i_wvalid = '0; tick();
        probe(P_SBLEFT, 0, "scoreboard_left");
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
